// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC select (stall > system > jump > branch > seq), fault detection, sticky halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int ADDR_W = 6,
  parameter int MEM_WORDS = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic branch_taken,
  input  logic [31:0] branch_target,
  input  logic jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] inst_in,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [31:0] inst_out,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic fetch_valid,
  output logic halted,
  output logic [1:0] fault,
  output logic [31:0] fetch_count
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc_n, count_n, cand;
  logic [1:0] fault_n;
  logic sys;
  assign sys = inst_in == 32'h0000_0073 || inst_in == 32'h0010_0073;
  assign cand = jump ? (jump_target & ~32'd1) : branch_taken ? branch_target : pc_plus4;
  assign inst_addr = pc[ADDR_W+1:2];
  assign pc_plus4 = pc + 32'd4;
  assign halted = state == HALT;
  assign fetch_valid = state == RUN && !stall;
  assign inst_out = fetch_valid ? inst_in : NOP;
  always_comb begin
    state_n = state;
    pc_n = pc;
    fault_n = fault;
    count_n = fetch_count;
    if (fetch_valid) begin
      if (sys || cand[1] || cand >= LIMIT) begin
        state_n = HALT;
        fault_n = sys ? 2'd3 : cand[1] ? 2'd1 : 2'd2;
      end else begin
        pc_n = cand;
        count_n = &fetch_count ? fetch_count : fetch_count + 32'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      fault <= 2'd0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      fault <= fault_n;
      fetch_count <= count_n;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan plus random stimulus against an architectural model of the fetch stage
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target, inst_in;
  logic [5:0] inst_addr;
  logic [31:0] inst_out, pc, pc_plus4, fetch_count;
  logic fetch_valid, halted;
  logic [1:0] fault;
  int passed = 0;
  int total = 0;
  logic [31:0] m_pc, m_cnt;
  logic m_halt;
  logic [1:0] m_fault;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .inst_in(inst_in), .inst_addr(inst_addr), .inst_out(inst_out), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .halted(halted),
    .fault(fault), .fetch_count(fetch_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask
  task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt, input logic [31:0] ins);
    logic [31:0] t;
    if (r) begin
      m_pc = 32'h0; m_halt = 1'b0; m_fault = 2'd0; m_cnt = 32'h0;
    end else if (!m_halt && !s) begin
      t = j ? {jt[31:1], 1'b0} : b ? bt : m_pc + 32'd4;
      if (ins == 32'h0000_0073 || ins == 32'h0010_0073) begin
        m_halt = 1'b1; m_fault = 2'd3;
      end else if (t % 4 == 2 || t % 4 == 3) begin
        m_halt = 1'b1; m_fault = 2'd1;
      end else if (t >= 32'd256) begin
        m_halt = 1'b1; m_fault = 2'd2;
      end else begin
        m_pc = t;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
  endtask
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic [31:0] ins);
    logic v;
    rst = r; stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt; inst_in = ins;
    #1;
    v = !m_halt && !s;
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, v});
    check("inst_out", inst_out, v ? ins : NOP);
    check("inst_addr", {26'd0, inst_addr}, (m_pc / 4) % 64);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    @(posedge clk);
    model_step(r, s, b, bt, j, jt, ins);
    #1;
    check("pc", pc, m_pc);
    check("halted", {31'd0, halted}, {31'd0, m_halt});
    check("fault", {30'd0, fault}, {30'd0, m_fault});
    check("fetch_count", fetch_count, m_cnt);
  endtask
  task automatic seq(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, NOP);
  endtask
  task automatic reset_dut();
    cycle(1, 0, 0, 0, 0, 0, NOP);
  endtask
  initial begin
    m_pc = 32'hx; m_halt = 1'bx; m_fault = 2'bx; m_cnt = 32'hx;
    reset_dut();
    check("reset_pc", pc, 32'h0);
    check("reset_count", fetch_count, 32'h0);
    seq(5);
    check("free_pc", pc, 32'h14);
    check("free_count", fetch_count, 32'd5);
    reset_dut();
    seq(2);
    cycle(0, 0, 1, 32'h20, 0, 0, NOP);
    check("branch_pc", pc, 32'h20);
    check("branch_addr", {26'd0, inst_addr}, 32'd8);
    cycle(0, 0, 1, 32'h8, 1, 32'h31, NOP);
    check("jump_wins", pc, 32'h30);
    cycle(0, 0, 0, 0, 1, 32'h22, NOP);
    check("misalign_fault", {30'd0, fault}, 32'd1);
    check("misalign_pc", pc, 32'h30);
    cycle(0, 0, 1, 32'h40, 0, 0, NOP);
    check("halt_nop", inst_out, NOP);
    check("halt_pc", pc, 32'h30);
    reset_dut();
    check("rst_halt_pc", pc, 32'h0);
    check("rst_halt_fault", {30'd0, fault}, 32'd0);
    seq(63);
    check("last_word_pc", pc, 32'hFC);
    cycle(0, 0, 0, 0, 0, 0, NOP);
    check("range_fault", {30'd0, fault}, 32'd2);
    check("range_pc", pc, 32'hFC);
    check("range_count", fetch_count, 32'd63);
    reset_dut();
    seq(4);
    cycle(0, 0, 1, 32'h40, 0, 0, 32'h0000_0073);
    check("ecall_fault", {30'd0, fault}, 32'd3);
    check("ecall_pc", pc, 32'h10);
    reset_dut();
    seq(4);
    cycle(0, 0, 0, 0, 0, 0, 32'h0010_0073);
    check("ebreak_fault", {30'd0, fault}, 32'd3);
    reset_dut();
    seq(5);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 1, 32'h40, NOP);
    check("stall_pc", pc, 32'h14);
    check("stall_count", fetch_count, 32'd5);
    seq(1);
    check("resume_pc", pc, 32'h18);
    cycle(1, 1, 0, 0, 1, 32'h40, NOP);
    check("rst_in_stall", pc, 32'h0);
    for (int i = 0; i < 600; i++) begin
      logic r, s, b, j;
      logic [31:0] bt, jt, ins;
      r = m_halt ? ($urandom_range(3) == 0) : ($urandom_range(59) == 0);
      s = $urandom_range(4) == 0;
      b = $urandom_range(5) == 0;
      j = $urandom_range(9) == 0;
      bt = $urandom_range(300);
      jt = $urandom_range(300);
      case ($urandom_range(79))
        0: ins = 32'h0000_0073;
        1: ins = 32'h0010_0073;
        default: ins = $urandom;
      endcase
      cycle(r, s, b, bt, j, jt, ins);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle RISC-V core: holds the program counter, drives the word address into the 64-word instruction memory and forwards the returned instruction to the decoder. Selects the next PC from sequential, branch and jump sources, and supports stalls. Detects misaligned or out-of-range targets and ECALL/EBREAK, then parks in a sticky HALT state until reset.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
- ADDR_W, 6, instruction-memory word-address width
- MEM_WORDS, 64, instruction-memory depth in words (≤ 2**ADDR_W)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and count this cycle
- branch_taken  in  1  take branch_target at next edge
- branch_target  in  32  byte address
- jump  in  1  JAL/JALR redirect
- jump_target  in  32  byte address; bit 0 cleared internally
- inst_in  in  32  instruction-memory read data for inst_addr
- inst_addr  out  ADDR_W  pc[ADDR_W+1:2] to instruction memory
- inst_out  out  32  instruction to decoder; 32'h0000_0013 (NOP) when fetch_valid=0
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4 (link value)
- fetch_valid  out  1  RUN state and stall=0
- halted  out  1  in HALT state
- fault  out  2  0 none, 1 misaligned target, 2 out of range, 3 ECALL/EBREAK
- fetch_count  out  32  instructions completed, saturating

## Operation
- States: RUN, HALT. Reset → RUN. Only reset leaves HALT.
- RUN, next-PC priority (evaluated each edge): stall > system halt > jump > branch_taken > sequential.
  - stall=1: PC, state, fetch_count unchanged; redirect inputs ignored.
  - System halt: inst_in == 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK) → HALT, fault=3, PC unchanged.
  - Candidate target: jump → {jump_target[31:1],1'b0}; branch → branch_target; else pc+4 (32-bit wrap).
  - Candidate[1]=1 → HALT, fault=1, PC unchanged.
  - Candidate ≥ MEM_WORDS*4 (unsigned) → HALT, fault=2, PC unchanged. Covers sequential fall-off at the last word and pc+4 wrap-around.
  - Otherwise PC ← candidate, fetch_count += 1 (holds at 32'hFFFF_FFFF).
- HALT: PC, fault, fetch_count frozen; all inputs except rst ignored; inst_out = NOP.
- fetch_count increments on every non-stalled RUN edge that does not enter HALT. The faulting or ECALL instruction is not counted.

## Timing
- PC, state, fault and fetch_count are registers updated on the rising edge of clk.
- inst_addr, pc_plus4, fetch_valid and inst_out are combinational from the registers, stall and inst_in. An instruction reaches the decoder in the same cycle its address is driven (zero-latency memory read).
- Redirects take effect at the next edge; there are no bubbles.
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, inst_addr=RESET_PC[ADDR_W+1:2], halted=0, fault=0, fetch_count=0. fetch_valid=!stall in the first cycle after reset.
- rst asserted in any state, including HALT or mid-stall, overrides everything at that edge.
- jump and branch_taken asserted together: jump wins.

## Test plan
- Reset, then 5 free-running cycles with NOPs: pc 0,4,8,12,16; inst_addr 0..4; fetch_count=5; fault=0.
- pc=8, branch_taken=1, branch_target=0x20: next pc=0x20, inst_addr=8. Repeat with jump=1, jump_target=0x31 at the same edge: jump wins, next pc=0x30.
- jump_target=0x22: halted=1, fault=1, pc frozen, inst_out=NOP. Then rst=1 for one edge: pc=0, fault=0, halted=0.
- Sequential run to pc=0xFC (MEM_WORDS=64): next edge halted=1, fault=2, pc stays 0xFC, fetch_count unchanged on that edge.
- inst_in=32'h0000_0073 at pc=0x10 with branch_taken=1: halted=1, fault=3, pc stays 0x10; branch ignored.
- stall=1 for 3 cycles at pc=0x14 with jump=1: pc, fetch_count unchanged, fetch_valid=0, inst_out=NOP. Release: normal advance resumes.
